// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the PC redirect unit.
//   state_t    : FSM encoding (RUN / HALT)
//   PC_STEP    : sequential fetch increment
//   ALIGN_MASK : low address bits that must be zero for a legal target
//   is_misaligned() : alignment test applied to branch and jump targets
package pc_redirect_unit_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_unit_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
//   clk, rst_n : clock, async active-low clear
//   inc        : add one this cycle (ignored once the count is all-ones)
//   count      : current value, holds at all-ones instead of wrapping
module pc_redirect_unit_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// PC redirect unit: owns the fetch PC and the IF/ID and ID/EXE flush lines.
// Build option: DELAY_SLOT_EN -- MIPS branch delay slot (taken branch flushes
// IF/ID only, jump flushes nothing).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_stall            hazard hold of PC and IF/ID
//   in_branch_taken     EXE branch resolved taken, target in in_branch_address
//   in_jump             ID jump decoded, target in in_jump_address
//   out_PC, out_PC_4    current fetch address and its +4
//   out_flush_IF_ID     clear IF/ID at next edge (combinational)
//   out_flush_ID_EXE    clear ID/EXE at next edge (combinational)
//   out_trap            misaligned-target trap, sticky until reset
//   out_branch_count    accepted aligned taken branches (saturating)
//   out_flush_count     RUN cycles with any flush high (saturating)
//   dbg_state           FSM state (0 = RUN, 1 = HALT)
//
// Request protocol: all requests are level signals sampled at every rising
// edge; there is no acknowledge. A request not honoured in a cycle (a jump
// under stall or under an older branch) must be re-presented by its source.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_stall,
    input  logic             in_branch_taken,
    input  logic [31:0]      in_branch_address,
    input  logic             in_jump,
    input  logic [31:0]      in_jump_address,
    output logic [31:0]      out_PC,
    output logic [31:0]      out_PC_4,
    output logic             out_flush_IF_ID,
    output logic             out_flush_ID_EXE,
    output logic             out_trap,
    output logic [CNT_W-1:0] out_branch_count,
    output logic [CNT_W-1:0] out_flush_count,
    output logic             dbg_state
);

`ifdef DELAY_SLOT_EN
    localparam logic DELAY_SLOT = 1'b1;
`else
    localparam logic DELAY_SLOT = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        branch_ok;
    logic        jump_ok;
    logic        branch_accept;

    assign branch_ok = in_branch_taken && !is_misaligned(in_branch_address);
    // A jump only counts when no branch is older and the hazard unit is not holding.
    assign jump_ok   = !in_branch_taken && !in_stall && in_jump
                       && !is_misaligned(in_jump_address);

    // State and PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state / next PC
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        branch_accept = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (in_branch_taken) begin
                    if (branch_ok) begin
                        pc_d          = in_branch_address;
                        branch_accept = 1'b1;
                    end else begin
                        state_d = ST_HALT;
                    end
                end else if (in_stall) begin
                    pc_d = pc_q;
                end else if (in_jump) begin
                    if (jump_ok) begin
                        pc_d = in_jump_address;
                    end else begin
                        state_d = ST_HALT;
                    end
                end else begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            ST_HALT: begin
                pc_d = pc_q;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Outputs: flushes follow the redirect in the same cycle; HALT holds
    // both flushes so nothing behind the faulting instruction advances.
    always_comb begin
        out_flush_IF_ID  = 1'b0;
        out_flush_ID_EXE = 1'b0;
        out_trap         = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_RUN: begin
                    if (branch_ok) begin
                        out_flush_IF_ID  = 1'b1;
                        out_flush_ID_EXE = !DELAY_SLOT;
                    end else if (jump_ok) begin
                        out_flush_IF_ID  = !DELAY_SLOT;
                    end
                end
                ST_HALT: begin
                    out_flush_IF_ID  = 1'b1;
                    out_flush_ID_EXE = 1'b1;
                    out_trap         = 1'b1;
                end
                default: begin
                    out_trap = 1'b1;
                end
            endcase
        end
    end

    assign out_PC    = pc_q;
    assign out_PC_4  = pc_q + PC_STEP;
    assign dbg_state = state_q;

    pc_redirect_unit_sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (branch_accept),
        .count (out_branch_count)
    );

    pc_redirect_unit_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state_q == ST_RUN) && (out_flush_IF_ID || out_flush_ID_EXE)),
        .count (out_flush_count)
    );

endmodule
